// File: rtl/ysyx_pipe_stage.sv
// Pipeline stage register with valid/ready handshake, flush and performance counters.
// SKID=1 uses a two-entry skid buffer with register-derived ready; SKID=0 holds one entry.
module ysyx_pipe_stage #(
    parameter int unsigned       DATA_W     = 160,
    parameter bit                SKID       = 1'b1,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    output logic [1:0]        o_count,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_bubble_cnt
);

    // State encoding equals the occupancy so o_count is a plain register copy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    state_e            state_r;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] skid_r;
    logic [31:0]       stall_cnt_r;
    logic [31:0]       bubble_cnt_r;
    logic              ready_s;
    logic              valid_s;
    logic              accept_s;
    logic              drain_s;

    assign valid_s  = (state_r != ST_EMPTY);
    assign accept_s = i_valid && ready_s;
    assign drain_s  = valid_s && i_ready;

    // Upstream ready: skid mode depends only on state, single-entry mode passes i_ready through.
    always_comb begin
        ready_s = 1'b0;
        if (SKID) begin
            ready_s = rst && (state_r != ST_FULL);
        end else begin
            ready_s = rst && ((state_r == ST_EMPTY) || i_ready);
        end
    end

    assign o_ready      = ready_s;
    assign o_valid      = valid_s;
    assign o_count      = state_r;
    assign o_data       = main_r;
    assign o_stall_cnt  = stall_cnt_r;
    assign o_bubble_cnt = bubble_cnt_r;

    // Occupancy FSM and payload registers; flush clears validity but leaves data untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            main_r  <= RESET_DATA;
            skid_r  <= RESET_DATA;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r  <= i_data;
                        state_r <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        main_r <= i_data;
                    end else if (accept_s) begin
                        skid_r  <= i_data;
                        state_r <= ST_FULL;
                    end else if (drain_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain_s) begin
                        main_r  <= skid_r;
                        state_r <= ST_ONE;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
            if (i_flush) begin
                state_r <= ST_EMPTY;
            end
        end
    end

    // Stall and bubble counters; free-running modulo 2^32, untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (valid_s && !i_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (!valid_s) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end
    end

endmodule

// File: doc/ysyx_pipe_stage.md
# ysyx_pipe_stage

Parametrised pipeline stage register with a valid/ready handshake, a flush input and performance counters. It is the successor to the free-running stage registers between IF/ID/EX/MEM/WB, which have no stall or kill ability. One instance sits at each stage boundary of the ysyx core. The stage's payload bus is concatenated into `i_data` and split again at `o_data`. Stall, back-pressure and branch/trap flush are handled uniformly in this block, with no logic per payload field.

## Interface
- `DATA_W`, default 160: payload width in bits, 1..1024.
- `SKID`, default 1:
  - 1: two-entry skid buffer with registered `o_ready`, giving full throughput.
  - 0: single entry with combinational `o_ready`.
- `RESET_DATA`, default 0: value loaded into the payload registers on reset. Width `DATA_W`.

- `clk` in 1: core clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_valid` in 1: upstream holds a valid payload.
- `o_ready` out 1: this stage can accept a payload this cycle.
- `i_data` in `DATA_W`: upstream payload.
- `o_valid` out 1: `o_data` holds a valid payload.
- `i_ready` in 1: downstream accepts `o_data` this cycle.
- `o_data` out `DATA_W`: head payload.
- `i_flush` in 1: discard every held payload and the payload entering this cycle.
- `o_count` out 2: number of occupied entries, 0..2.
- `o_stall_cnt` out 32: count of cycles with `o_valid && !i_ready`.
- `o_bubble_cnt` out 32: count of cycles with `!o_valid`, counted only after reset release.

## Operation
- **Transfers**
  - Upstream transfer (accept) = `i_valid && o_ready`.
  - Downstream transfer (drain) = `o_valid && i_ready`.
  - Payload order is strictly FIFO. A payload is never duplicated or dropped except by flush.
- **SKID=1 state**
  - Entries: `main` (drives `o_data`/`o_valid`) and `skid`.
  - States: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
  - `o_ready = rst && !skid_valid`. It is a register-derived signal with no combinational path from `i_ready`.
- **SKID=1 transitions** (no flush)
  - EMPTY + accept → ONE. `main <= i_data`.
  - ONE + accept + drain → ONE. `main <= i_data`.
  - ONE + accept, no drain → FULL. `skid <= i_data`.
  - ONE + drain, no accept → EMPTY.
  - FULL + drain → ONE. `main <= skid`. No accept is possible in FULL because `o_ready` = 0.
  - Any state with neither accept nor drain → unchanged. `o_data` stays stable while `o_valid && !i_ready`.
- **SKID=0**
  - Single `main` entry.
  - `o_ready = rst && (!o_valid || i_ready)`.
  - States are EMPTY and ONE only. `o_count` never exceeds 1.
- **Flush**
  - `i_flush` high at an edge forces all valid bits to 0, giving state EMPTY.
  - It has priority over accept and drain.
  - A payload accepted in the flush cycle is discarded. Upstream still sees its handshake complete.
  - A drain in the flush cycle is still a completed downstream transfer. Downstream must ignore it if it is also flushed.
  - Payload data registers are not rewritten by flush. Only the valid bits clear.
- **Counters**
  - 32-bit, wrap modulo 2^32, cleared only by reset.
  - Flush does not affect the counters.
  - `o_bubble_cnt` increments on every edge after reset release where `o_valid` = 0 before the edge.
- **Data gating**
  - Payload registers load only on accept or skid-to-main move.
  - `o_data` is undefined-but-stable (last loaded value) when `o_valid` = 0.

## Timing
- **Reset** (`rst` low, asynchronous):
  - `o_valid` = 0, `o_count` = 0, `o_ready` = 0.
  - `o_data` = `RESET_DATA`.
  - Both counters = 0.
  - The first accept is possible on the first rising edge after `rst` goes high.
- **Reset mid-operation:** all held payloads are lost immediately, with no completion of a pending drain.
- **Latency:** a payload accepted at edge N appears on `o_data` with `o_valid` = 1 after edge N, so it can drain at edge N+1.
- **Throughput:** one payload per cycle sustained in both `SKID` modes when `i_ready` is held at 1.
- **SKID=1 recovery:** after `i_ready` rises, `o_ready` rises one cycle after the FULL→ONE drain.
- **Flush latency:** `o_valid` = 0 in the cycle after the flush edge. Accept resumes in that same cycle, because `o_ready` = 1 when empty.

## Test plan
- **Reset:** reset with `RESET_DATA`=0xABC → `o_valid`=0, `o_data`=0xABC, `o_ready`=0, counters 0. After release, `o_ready`=1 and `o_bubble_cnt` increments by 1 per cycle.
- **Streaming:** stream 0x1..0x8 with `i_valid`=`i_ready`=1 continuously (SKID=1 and SKID=0) → `o_data` = 0x1..0x8 in order, one per cycle, first at 1 cycle latency, `o_stall_cnt`=0.
- **Back-pressure, SKID=1:** accept 0x10, 0x11, 0x12 with `i_ready`=0 → after 2 accepts `o_count`=2 and `o_ready`=0. 0x12 is held upstream. Raise `i_ready` → outputs 0x10, 0x11, 0x12 in order. `o_stall_cnt` equals the number of blocked cycles.
- **Flush while full:** fill to FULL (0x20, 0x21), assert `i_flush` for one cycle while `i_valid` carries 0x22 → next cycle `o_valid`=0, `o_count`=0. 0x22 never appears. The following input 0x23 is output as the next payload.
- **Combinational ready, SKID=0:** with `o_valid`=1, toggle `i_ready` → `o_ready` follows `i_ready` within the same cycle. Simultaneous accept and drain replaces the payload with no bubble.
- **Counter wrap and reset mid-operation:** preload `o_stall_cnt` to 0xFFFFFFFF via a forced stall count, stall one more cycle → counter reads 0. Assert `rst` low mid-stream → all outputs at reset values immediately, without waiting for a clock edge.
